rr_arbiter_8: RTL

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

---
 rtl/rr_arbiter_8.sv | 103 ++++++++++
 1 files changed

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with registered grant and a two-state IDLE/BUSY controller.
// Optional forced release of long-held grants is enabled by defining GRANT_TIMEOUT_EN.
module rr_arbiter_8 #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout_err
);

  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_chk
    $error("TIMEOUT_CYCLES out of range 1..255");
  end

  logic       state;
  logic [2:0] ptr;
  logic [2:0] winner;
  logic [2:0] cand;
  logic       rel;

  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    winner = ptr;
    cand   = ptr;
    for (int i = 7; i >= 0; i--) begin
      cand = ptr + 3'(i);
      if (req[cand]) winner = cand;
    end
  end

  assign rel = done | ~req[gnt_idx];

`ifdef GRANT_TIMEOUT_EN
  logic [7:0] hold;
  logic       expire;

  assign expire = (hold == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      hold        <= 8'd0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      if (state == IDLE) begin
        hold <= 8'd0;
      end else if (!rel) begin
        hold <= hold + 8'd1;
        if (expire) timeout_err <= 1'b1;
      end
    end
  end
`else
  logic expire;

  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      gnt       <= 8'd0;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            state     <= BUSY;
            ptr       <= winner + 3'd1;
            gnt       <= 8'd1 << winner;
            gnt_idx   <= winner;
            gnt_valid <= 1'b1;
          end
        end
        BUSY: begin
          // A normal release takes precedence over an expiring timer.
          if (rel || expire) begin
            state     <= IDLE;
            gnt       <= 8'd0;
            gnt_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= 8'd0;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
